// File: rtl/shift_arbiter.sv
// -----------------------------------------------------------------------------
// shift_arbiter
//
// Two requesters share one 16-bit barrel shifter. Port 0 is the execute stage
// and port 1 is memory-stage alignment. Each cycle at most one request is
// granted. Its operand goes through the shared shifter, and the result is
// captured in a single output register with one cycle of latency.
//
// Handshake (both request ports and the output port):
//   A transfer happens on a rising edge where valid and ready are both 1.
//   A requester holds valid/data/ctrl stable until it sees ready. reqN_ready is
//   combinational and is 1 only in the cycle port N is granted. The output
//   register presents out_valid/out_data/out_src and holds them until the
//   consumer raises out_ready.
//
// Parameters
//   PRIORITY_MODE  0 = round-robin on contention, 1 = port 0 always wins
//
// Ports
//   clk         in   clock, all state updates on the rising edge
//   rst         in   synchronous active-high reset (highest precedence)
//   flush       in   synchronous active-high flush (beats any grant)
//   req0_valid  in   port 0 request present
//   req0_data   in   port 0 16-bit operand
//   req0_ctrl   in   port 0 control: [3:0] amount, [4] right, [5] arithmetic
//   req0_ready  out  port 0 granted this cycle
//   req1_*           same set for port 1
//   out_valid   out  output register holds a result
//   out_data    out  registered shift result
//   out_src     out  index of the port that produced out_data
//   out_ready   in   consumer takes out_data this cycle
// -----------------------------------------------------------------------------
module shift_arbiter #(
   parameter int PRIORITY_MODE = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,

   input  logic        req0_valid,
   input  logic [15:0] req0_data,
   input  logic [5:0]  req0_ctrl,
   output logic        req0_ready,

   input  logic        req1_valid,
   input  logic [15:0] req1_data,
   input  logic [5:0]  req1_ctrl,
   output logic        req1_ready,

   output logic        out_valid,
   output logic [15:0] out_data,
   output logic        out_src,
   input  logic        out_ready
);

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic        out_valid_q, out_valid_d;
   logic [15:0] out_data_q,  out_data_d;
   logic        out_src_q,   out_src_d;
   // Index of the most recently granted port. It resets to 1 so that port 0
   // wins the first contention.
   logic        last_grant_q, last_grant_d;

   // ---------------------------------------------------------------------------
   // Arbitration
   // ---------------------------------------------------------------------------
   logic slot_free;
   logic can_grant;
   logic port0_wins_tie;
   logic gnt0;
   logic gnt1;
   logic any_gnt;

   always_comb begin
      // The output register can take a new result when it is empty, or when
      // its current result drains in this same cycle.
      slot_free = !out_valid_q || out_ready;
      can_grant = slot_free && !flush && !rst;

      // On contention in fixed-priority mode port 0 always wins. In
      // round-robin mode the port that was not granted last wins.
      if (PRIORITY_MODE == 1) begin
         port0_wins_tie = 1'b1;
      end else begin
         port0_wins_tie = last_grant_q;
      end

      gnt0    = can_grant && req0_valid && (!req1_valid || port0_wins_tie);
      gnt1    = can_grant && req1_valid && !gnt0;
      any_gnt = gnt0 || gnt1;
   end

   assign req0_ready = gnt0;
   assign req1_ready = gnt1;

   // ---------------------------------------------------------------------------
   // Shared shifter
   //
   // Only a right shifter is built. A left shift is done by bit-reversing the
   // operand, shifting it right with zero fill, and reversing the result.
   // The operand comes from whichever port holds the grant. When nothing is
   // granted the result is unused.
   // ---------------------------------------------------------------------------
   logic [15:0] sh_operand;
   logic [5:0]  sh_ctrl;
   logic [3:0]  sh_amount;
   logic        sh_right;
   logic        sh_fill;
   logic [15:0] sh_stage0;
   logic [15:0] sh_stage1;
   logic [15:0] sh_stage2;
   logic [15:0] sh_stage3;
   logic [15:0] sh_stage4;
   logic [15:0] sh_result;

   always_comb begin
      sh_operand = gnt1 ? req1_data : req0_data;
      sh_ctrl    = gnt1 ? req1_ctrl : req0_ctrl;
      sh_amount  = sh_ctrl[3:0];
      sh_right   = sh_ctrl[4];
      // The arithmetic bit only applies to right shifts.
      sh_fill    = sh_right && sh_ctrl[5] && sh_operand[15];

      sh_stage0 = 16'h0000;
      for (int b = 0; b < 16; b++) begin
         sh_stage0[b] = sh_right ? sh_operand[b] : sh_operand[15 - b];
      end

      sh_stage1 = sh_amount[0] ? {sh_fill, sh_stage0[15:1]}       : sh_stage0;
      sh_stage2 = sh_amount[1] ? {{2{sh_fill}}, sh_stage1[15:2]}  : sh_stage1;
      sh_stage3 = sh_amount[2] ? {{4{sh_fill}}, sh_stage2[15:4]}  : sh_stage2;
      sh_stage4 = sh_amount[3] ? {{8{sh_fill}}, sh_stage3[15:8]}  : sh_stage3;

      sh_result = 16'h0000;
      for (int b = 0; b < 16; b++) begin
         sh_result[b] = sh_right ? sh_stage4[b] : sh_stage4[15 - b];
      end
   end

   // ---------------------------------------------------------------------------
   // Output register next state (the precedence order is reset, flush, grant,
   // drain)
   // ---------------------------------------------------------------------------
   always_comb begin
      out_valid_d  = out_valid_q;
      out_data_d   = out_data_q;
      out_src_d    = out_src_q;
      last_grant_d = last_grant_q;

      if (rst) begin
         out_valid_d  = 1'b0;
         out_data_d   = 16'h0000;
         out_src_d    = 1'b0;
         last_grant_d = 1'b1;
      end else if (flush) begin
         // A flush drops the held result but keeps its data and the
         // arbitration history.
         out_valid_d = 1'b0;
      end else if (any_gnt) begin
         out_valid_d  = 1'b1;
         out_data_d   = sh_result;
         out_src_d    = gnt1;
         last_grant_d = gnt1;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_src_q    <= out_src_d;
      last_grant_q <= last_grant_d;
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_src   = out_src_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// -----------------------------------------------------------------------------
// tb_shift_arbiter
//
// This bench drives a round-robin instance (u_rr) and a fixed-priority
// instance (u_fp) from a linear sequence of directed steps, followed by a
// randomized phase. A behavioural model gives the expected ready outputs
// every cycle and the expected output register after every edge.
// -----------------------------------------------------------------------------
module tb_shift_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        fl    [2];
   logic        v0    [2];
   logic        v1    [2];
   logic [15:0] d0    [2];
   logic [15:0] d1    [2];
   logic [5:0]  c0    [2];
   logic [5:0]  c1    [2];
   logic        rdy0  [2];
   logic        rdy1  [2];
   logic        ov    [2];
   logic [15:0] od    [2];
   logic        osrc  [2];
   logic        ordy  [2];

   shift_arbiter #(.PRIORITY_MODE(0)) u_rr (
      .clk(clk), .rst(rst), .flush(fl[0]),
      .req0_valid(v0[0]), .req0_data(d0[0]), .req0_ctrl(c0[0]), .req0_ready(rdy0[0]),
      .req1_valid(v1[0]), .req1_data(d1[0]), .req1_ctrl(c1[0]), .req1_ready(rdy1[0]),
      .out_valid(ov[0]), .out_data(od[0]), .out_src(osrc[0]), .out_ready(ordy[0])
   );

   shift_arbiter #(.PRIORITY_MODE(1)) u_fp (
      .clk(clk), .rst(rst), .flush(fl[1]),
      .req0_valid(v0[1]), .req0_data(d0[1]), .req0_ctrl(c0[1]), .req0_ready(rdy0[1]),
      .req1_valid(v1[1]), .req1_data(d1[1]), .req1_ctrl(c1[1]), .req1_ready(rdy1[1]),
      .out_valid(ov[1]), .out_data(od[1]), .out_src(osrc[1]), .out_ready(ordy[1])
   );

   int checks = 0;
   int errors = 0;

   // Reference model state, one entry per instance.
   logic        m_valid [2];
   logic [15:0] m_data  [2];
   logic        m_src   [2];
   int          m_last  [2];
   int          m_gnt   [2];   // -1 = no grant this cycle

   function automatic logic [15:0] ref_shift(logic [15:0] d, logic [5:0] c);
      int amt;
      amt = int'(c[3:0]);
      if (!c[4]) return d << amt;
      if (c[5])  return 16'($signed(d) >>> amt);
      return d >> amt;
   endfunction

   // Instance 1 is the fixed-priority one.
   function automatic int ref_grant(int i);
      bit room;
      room = !m_valid[i] || ordy[i];
      if (rst || fl[i] || !room) return -1;
      if (v0[i] && v1[i]) begin
         if (i == 1) return 0;
         return (m_last[i] == 0) ? 1 : 0;
      end
      if (v0[i]) return 0;
      if (v1[i]) return 1;
      return -1;
   endfunction

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock cycle. The inputs are already set at the negedge. The task
   // checks the readies, advances the model across the edge, and then checks
   // the registers.
   task automatic cycle(input string tag);
      #1;
      for (int i = 0; i < 2; i++) begin
         m_gnt[i] = ref_grant(i);
         check($sformatf("%s_u%0d_rdy0", tag, i), 16'(rdy0[i]), 16'(m_gnt[i] == 0));
         check($sformatf("%s_u%0d_rdy1", tag, i), 16'(rdy1[i]), 16'(m_gnt[i] == 1));
      end
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            m_valid[i] = 1'b0; m_data[i] = 16'h0000; m_src[i] = 1'b0; m_last[i] = 1;
         end else if (fl[i]) begin
            m_valid[i] = 1'b0;
         end else if (m_gnt[i] == 0) begin
            m_valid[i] = 1'b1; m_data[i] = ref_shift(d0[i], c0[i]); m_src[i] = 1'b0; m_last[i] = 0;
         end else if (m_gnt[i] == 1) begin
            m_valid[i] = 1'b1; m_data[i] = ref_shift(d1[i], c1[i]); m_src[i] = 1'b1; m_last[i] = 1;
         end else if (ordy[i]) begin
            m_valid[i] = 1'b0;
         end
      end
      #1;
      for (int i = 0; i < 2; i++) begin
         check($sformatf("%s_u%0d_ov", tag, i), 16'(ov[i]), 16'(m_valid[i]));
         check($sformatf("%s_u%0d_od", tag, i), od[i], m_data[i]);
         check($sformatf("%s_u%0d_src", tag, i), 16'(osrc[i]), 16'(m_src[i]));
      end
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      for (int i = 0; i < 2; i++) begin
         fl[i] = 1'b0; v0[i] = 1'b0; v1[i] = 1'b0; ordy[i] = 1'b1;
         d0[i] = 16'h0000; d1[i] = 16'h0000; c0[i] = 6'h00; c1[i] = 6'h00;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cycle("reset");
      rst = 1'b0;
   endtask

   logic [15:0] held;
   int          exp_rr [4];

   initial begin
      rst = 1'b1;
      idle_inputs();
      for (int i = 0; i < 2; i++) begin
         m_valid[i] = 1'b0; m_data[i] = 16'h0000; m_src[i] = 1'b0; m_last[i] = 1; m_gnt[i] = -1;
      end
      @(negedge clk);

      // Reset with requests present: no ready, and the registers are cleared.
      v0[0] = 1'b1; v1[0] = 1'b1; v0[1] = 1'b1; v1[1] = 1'b1;
      cycle("rst_a");
      check("rst_rdy0_const", 16'(rdy0[0]), 16'h0);
      cycle("rst_b");
      check("rst_ov_const", 16'(ov[0]), 16'h0);
      check("rst_od_const", od[0], 16'h0000);
      idle_inputs();
      rst = 1'b0;

      // Single-port shift.
      v0[0] = 1'b1; d0[0] = 16'h8001; c0[0] = 6'h01;
      #1 check("single_rdy0_const", 16'(rdy0[0]), 16'h1);
      cycle("single");
      check("single_od_const", od[0], 16'h0002);
      check("single_src_const", 16'(osrc[0]), 16'h0);

      // Right shifts and the ignored mode bit on a left shift.
      d0[0] = 16'h8000;
      c0[0] = 6'h34; cycle("sh34"); check("sh34_const", od[0], 16'hF800);
      c0[0] = 6'h14; cycle("sh14"); check("sh14_const", od[0], 16'h0800);
      c0[0] = 6'h24; cycle("sh24"); check("sh24_const", od[0], 16'h0000);
      c0[0] = 6'h10; cycle("sh10"); check("sh10_const", od[0], 16'h8000);
      idle_inputs();

      // Round-robin from reset.
      do_reset();
      exp_rr[0] = 0; exp_rr[1] = 1; exp_rr[2] = 0; exp_rr[3] = 1;
      v0[0] = 1'b1; v1[0] = 1'b1; d0[0] = 16'h00F0; d1[0] = 16'h0F00; c0[0] = 6'h02; c1[0] = 6'h13;
      for (int k = 0; k < 4; k++) begin
         #1 check($sformatf("rr_gnt1_%0d", k), 16'(rdy1[0]), 16'(exp_rr[k]));
         cycle("rr");
         check($sformatf("rr_src_%0d", k), 16'(osrc[0]), 16'(exp_rr[k]));
      end
      idle_inputs();

      // Backpressure.
      do_reset();
      v0[0] = 1'b1; d0[0] = 16'h1234; c0[0] = 6'h04;
      cycle("bp_load");
      held = 16'h2340;
      v1[0] = 1'b1; d1[0] = 16'hABCD; c1[0] = 6'h18; ordy[0] = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1 check("bp_rdy_const", 16'({rdy0[0], rdy1[0]}), 16'h0);
         cycle("bp_hold");
         check("bp_od_stable", od[0], held);
      end
      ordy[0] = 1'b1;
      #1 check("bp_regrant_rdy1", 16'(rdy1[0]), 16'h1);
      cycle("bp_release");
      check("bp_new_od", od[0], 16'h00AB);
      check("bp_new_src", 16'(osrc[0]), 16'h1);

      // Flush while a result is held and port 1 is requesting. last_grant
      // is 1 here, so the next contention goes to port 0.
      v0[0] = 1'b0; v1[0] = 1'b1; fl[0] = 1'b1; ordy[0] = 1'b0;
      cycle("flush");
      check("flush_ov_const", 16'(ov[0]), 16'h0);
      check("flush_od_hold", od[0], 16'h00AB);
      fl[0] = 1'b0; v0[0] = 1'b1; ordy[0] = 1'b1;
      #1 check("flush_next_rdy0", 16'(rdy0[0]), 16'h1);
      cycle("after_flush");
      idle_inputs();

      // Fixed-priority instance: port 0 wins for four straight cycles.
      v0[1] = 1'b1; v1[1] = 1'b1; d0[1] = 16'h0001; d1[1] = 16'hFFFF; c1[1] = 6'h31;
      for (int k = 0; k < 4; k++) begin
         c0[1] = 6'(k);
         #1 check("fp_rdy1_const", 16'(rdy1[1]), 16'h0);
         cycle("fp");
         check("fp_src_const", 16'(osrc[1]), 16'h0);
      end
      idle_inputs();

      // A reset while a result is held discards the result.
      v0[0] = 1'b1; d0[0] = 16'h00FF; c0[0] = 6'h08; ordy[0] = 1'b0;
      cycle("rh_load");
      v0[0] = 1'b0;
      do_reset();
      check("rh_ov_const", 16'(ov[0]), 16'h0);
      idle_inputs();

      // Randomized traffic. Each requester holds its request until it is
      // accepted.
      for (int n = 0; n < 400; n++) begin
         rst = ($urandom_range(0, 63) == 0);
         for (int i = 0; i < 2; i++) begin
            if (!v0[i] && $urandom_range(0, 1) == 1) begin
               v0[i] = 1'b1; d0[i] = 16'($urandom); c0[i] = 6'($urandom);
            end
            if (!v1[i] && $urandom_range(0, 1) == 1) begin
               v1[i] = 1'b1; d1[i] = 16'($urandom); c1[i] = 6'($urandom);
            end
            ordy[i] = ($urandom_range(0, 3) != 0);
            fl[i]   = ($urandom_range(0, 15) == 0);
         end
         cycle("rand");
         for (int i = 0; i < 2; i++) begin
            if (m_gnt[i] == 0) v0[i] = 1'b0;
            if (m_gnt[i] == 1) v1[i] = 1'b0;
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/shift_arbiter.md
SHIFT_ARBITER -- requirements
Module: shift_arbiter

Interface
REQ-001 The block SHALL have parameter PRIORITY_MODE, default 0, meaning 0 = round-robin arbitration and 1 = fixed priority with port 0 winning.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port flush, input, 1 bit: pipeline flush, synchronous and active-high.
REQ-005 The block SHALL have port req0_valid, input, 1 bit: port 0 (execute stage) request present.
REQ-006 The block SHALL have port req0_data, input, 16 bits: port 0 value to shift.
REQ-007 The block SHALL have port req0_ctrl, input, 6 bits: port 0 shift control in IR[5:0] format.
REQ-008 The block SHALL have port req0_ready, output, 1 bit: port 0 request accepted this cycle.
REQ-009 The block SHALL have ports req1_valid, req1_data, req1_ctrl and req1_ready, identical to port 0 but for port 1 (memory-stage alignment).
REQ-010 The block SHALL have port out_valid, output, 1 bit: registered result valid.
REQ-011 The block SHALL have port out_data, output, 16 bits: registered shift result.
REQ-012 The block SHALL have port out_src, output, 1 bit: index of the port that produced out_data.
REQ-013 The block SHALL have port out_ready, input, 1 bit: consumer accepts out_data this cycle.

Function
REQ-014 The block SHALL decode ctrl[3:0] as the shift amount (0-15), ctrl[4] as direction (0 = left, 1 = right) and ctrl[5] as mode (1 = arithmetic, applied to right shifts only).
REQ-015 Left shifts and logical right shifts SHALL fill vacated bits with 0; arithmetic right shifts SHALL fill vacated bits with data[15].
REQ-016 The block SHALL ignore ctrl[5] when ctrl[4] = 0.
REQ-017 A shift amount of 0 SHALL pass the data through unchanged.
REQ-018 The block SHALL use exactly one shared shifter datapath, with its operand selected by the grant.
REQ-019 The output register SHALL be able to accept a new result ("slot free") when out_valid = 0, or when out_valid = 1 and out_ready = 1 (drain and refill in the same cycle).
REQ-020 The block SHALL grant at most one port per cycle, and only when the slot is free, flush = 0 and rst = 0.
REQ-021 When exactly one port is valid, that port SHALL be granted.
REQ-022 When both ports are valid and PRIORITY_MODE = 0, the port not equal to last_grant SHALL be granted.
REQ-023 When both ports are valid and PRIORITY_MODE = 1, port 0 SHALL always be granted.
REQ-024 last_grant SHALL update to the granted port on every grant and hold otherwise.
REQ-025 reqN_ready SHALL be combinational and equal 1 only in the cycle port N is granted; a request is transferred when reqN_valid and reqN_ready are both 1.
REQ-026 On a grant, out_data, out_src and out_valid = 1 SHALL load at the next edge (latency 1 cycle).
REQ-027 When out_valid = 1 and out_ready = 0, out_data and out_src SHALL hold stable and both ready outputs SHALL be 0.
REQ-028 When out_valid = 1, out_ready = 1 and there is no grant, out_valid SHALL clear at the next edge.
REQ-029 When flush = 1, out_valid SHALL clear at the next edge, no grant SHALL occur, last_grant SHALL hold and out_data SHALL hold.
REQ-030 rst SHALL take precedence over flush, and flush SHALL take precedence over grants.
REQ-031 Requesters SHALL hold valid, data and ctrl stable until accepted; the block SHALL not buffer unaccepted requests.

Reset
REQ-032 While rst = 1 at an edge, the block SHALL load out_valid = 0, out_data = 0x0000, out_src = 0 and last_grant = 1, so port 0 wins the first contention.
REQ-033 While rst = 1, req0_ready and req1_ready SHALL be 0.
REQ-034 A reset asserted while a result is held SHALL discard that result.

Verification
REQ-035 Single-port shift: after reset, req0 data 0x8001, ctrl 0x01 -> req0_ready = 1 the same cycle; next cycle out_valid = 1, out_data = 0x0002, out_src = 0.
REQ-036 Right shifts: data 0x8000 with ctrl 0x34 -> 0xF800; with ctrl 0x14 -> 0x0800; with ctrl 0x24 (left, mode ignored) -> 0x0000; with ctrl 0x10 -> 0x8000.
REQ-037 Round-robin: both ports valid continuously with out_ready = 1 after reset -> grants 0, 1, 0, 1, with out_src following one cycle later.
REQ-038 Backpressure: out_valid = 1, out_ready = 0 for 3 cycles with both ports valid -> ready outputs 0 and out_data stable; then out_ready = 1 -> a new grant occurs in that same cycle and the new result appears next cycle.
REQ-039 Flush: out_valid = 1 and req1 valid, flush = 1 -> next cycle out_valid = 0, no ready asserted, and last_grant unchanged (verified by the next contention outcome).
REQ-040 PRIORITY_MODE = 1: both ports valid for 4 cycles -> port 0 granted every cycle and req1_ready held at 0.
